sdpram_fifo_ctrl: RTL and testbench

//  Sequences one simple dual-port RAM (write port A, read port B) as a synchronous FIFO.
//  - Upstream: valid/ready push stream. Downstream: valid/ready pop stream.
//  - Owns addra/wena/dina and addrb/renb; consumes doutb/dvalb.
//  - Presents full/empty/count to the surrounding datapath.

---
 rtl/sdpram_fifo_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_sdpram_fifo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sdpram_fifo_ctrl
//   Runs one external simple dual-port RAM (port A write, port B read) as a
//   synchronous FIFO. Pushes pass straight through to port A. Reads are issued
//   on port B against a credit held by a 2-entry output skid buffer, so the
//   RAM read latency never needs back-pressure.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   flush         synchronous clear; in-flight reads are drained and dropped
//   s_valid/s_ready/s_data   push stream
//   m_valid/m_ready/m_data   pop stream (m_data is a register)
//   count/full/empty         occupancy: RAM + in-flight + output buffer
//   addra/wena/dina          RAM write port
//   addrb/renb               RAM read request
//   doutb/dvalb              RAM read return (in order, fixed latency >= 1)
//   err_ovf/err_dvalb        sticky error flags, only with SDPFIFO_ERR_EN
//
// Build option
//   SDPFIFO_ERR_EN : adds err_ovf (push attempted while full) and err_dvalb
//                    (unexpected read return). Cleared only by rst.
// -----------------------------------------------------------------------------
module sdpram_fifo_ctrl #(
  parameter int  DATA_WIDTH = 32,
  parameter int  MEM_DEPTH  = 1024,
  parameter int  BYTE_WRITE = 0,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int STRB_WIDTH = (BYTE_WRITE != 0) ? DATA_WIDTH / 8 : 1,
  localparam int CNT_W      = ADDR_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [STRB_WIDTH-1:0] wena,
  output logic [DATA_WIDTH-1:0] dina,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  renb,
  input  logic [DATA_WIDTH-1:0] doutb,
  input  logic                  dvalb
`ifdef SDPFIFO_ERR_EN
  ,
  output logic                  err_ovf,
  output logic                  err_dvalb
`endif
);

  localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;  // words written to RAM, not yet read
  logic                  pend_q, pend_d;        // last cycle's push, not yet readable
  logic [1:0]            infl_q, infl_d;        // reads issued, data not yet returned
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;        // obuf slot 0, drives m_data
  logic [DATA_WIDTH-1:0] tail_q, tail_d;        // obuf slot 1

  logic       run;
  logic       push;
  logic       wr_en;
  logic       pop;
  logic       avail;
  logic       credit_ok;
  logic       rd_en;
  logic       dv_take;
  logic       obuf_wr;
  logic [1:0] cnt_after_pop;

  // ---------------------------------------------------------------------------
  // Handshakes and RAM requests
  // ---------------------------------------------------------------------------
  assign run     = (state_q == RUN);
  assign full    = (ram_cnt_q == RAM_FULL);
  assign s_ready = run && !full;
  assign push    = s_valid && s_ready;
  // flush wins over a push in the same cycle: the word is not written.
  assign wr_en   = push && !flush;

  assign m_valid = (obuf_cnt_q != 2'd0);
  assign pop     = m_valid && m_ready && !flush;

  // The word pushed last cycle is counted in ram_cnt (so full is exact) but is
  // held back from reads for one cycle.
  assign avail     = (ram_cnt_q > {{ADDR_WIDTH{1'b0}}, pend_q});
  // Buffered + in-flight words never exceed the two obuf slots. A pop in the
  // same cycle frees a slot, which is what keeps one word/cycle streaming.
  assign credit_ok = (({1'b0, obuf_cnt_q} + {1'b0, infl_q}) < 3'd2);
  assign rd_en     = run && !flush && avail && (credit_ok || pop);

  // A return with nothing outstanding is not counted and not stored.
  assign dv_take = dvalb && (infl_q != 2'd0);
  assign obuf_wr = dv_take && run && !flush;

  assign addra = wr_ptr_q;
  assign wena  = {STRB_WIDTH{wr_en}};
  assign dina  = s_data;
  assign addrb = rd_ptr_q;
  assign renb  = rd_en;

  assign m_data = head_q;
  assign count  = CNT_W'(ram_cnt_q) + CNT_W'(infl_q) + CNT_W'(obuf_cnt_q);
  assign empty  = (count == '0);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_d     = wr_en;
    ram_cnt_d  = ram_cnt_q + (ADDR_WIDTH + 1)'(wr_en) - (ADDR_WIDTH + 1)'(rd_en);
    infl_d     = infl_q + {1'b0, rd_en} - {1'b0, dv_take};
    head_d     = head_q;
    tail_d     = tail_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    // Skid buffer: pop shifts slot 1 into the head, then a returning word
    // lands in the first free slot.
    cnt_after_pop = obuf_cnt_q - {1'b0, pop};
    obuf_cnt_d    = cnt_after_pop;
    if (pop && obuf_cnt_q == 2'd2) head_d = tail_q;
    if (obuf_wr && cnt_after_pop != 2'd2) begin
      if (cnt_after_pop == 2'd0) head_d = doutb;
      else                       tail_d = doutb;
      obuf_cnt_d = cnt_after_pop + 2'd1;
    end

    unique case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      // Leave as soon as the last outstanding return is consumed this cycle,
      // so a flush with nothing left in flight costs only one cycle.
      DRAIN:   if (!flush && infl_d == 2'd0) state_d = RUN;
      default: state_d = RUN;
    endcase

    // In-flight reads survive a flush (infl_d above); everything else clears.
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      pend_d     = 1'b0;
      obuf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      pend_q     <= 1'b0;
      infl_q     <= '0;
      obuf_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      pend_q     <= pend_d;
      infl_q     <= infl_d;
      obuf_cnt_q <= obuf_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef SDPFIFO_ERR_EN
  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic err_ovf_q;
  logic err_dvalb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q   <= 1'b0;
      err_dvalb_q <= 1'b0;
    end else begin
      if (s_valid && full) err_ovf_q <= 1'b1;
      if (dvalb && (infl_q == 2'd0 || obuf_cnt_q == 2'd2)) err_dvalb_q <= 1'b1;
    end
  end

  assign err_ovf   = err_ovf_q;
  assign err_dvalb = err_dvalb_q;
`endif

endmodule

// File: tb/tb_sdpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdpram_fifo_ctrl
//   Bench for sdpram_fifo_ctrl with a 1-cycle-latency RAM model
//   (dvalb = renb delayed by one clock). Data ordering is checked by a
//   scoreboard queue; per-cycle handshake/count behaviour by a vector table.
// -----------------------------------------------------------------------------
module tb_sdpram_fifo_ctrl;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int SW    = 2;
  localparam int CW    = AW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, m_valid, full, empty, renb, dvalb;
  logic [DW-1:0] m_data, dina, doutb;
  logic [CW-1:0] count;
  logic [AW-1:0] addra, addrb;
  logic [SW-1:0] wena;
`ifdef SDPFIFO_ERR_EN
  logic          err_ovf, err_dvalb;
`endif

  always #5 clk = ~clk;

  sdpram_fifo_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BYTE_WRITE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty),
    .addra(addra), .wena(wena), .dina(dina),
    .addrb(addrb), .renb(renb), .doutb(doutb), .dvalb(dvalb)
`ifdef SDPFIFO_ERR_EN
    , .err_ovf(err_ovf), .err_dvalb(err_dvalb)
`endif
  );

  // RAM model: byte-enable write, 1-cycle read
  logic [DW-1:0] mem [DEPTH];
  logic          ram_dv;
  logic          inj = 1'b0;
  always @(posedge clk) begin
    for (int b = 0; b < SW; b++)
      if (wena[b]) mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
    if (renb) doutb <= mem[addrb];
  end
  always @(posedge clk or posedge rst)
    if (rst) ram_dv <= 1'b0;
    else     ram_dv <= renb;
  assign dvalb = ram_dv | inj;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted pushes enqueue, pops compare against the head.
  logic [DW-1:0] sb_q[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (flush) sb_q.delete();
      else begin
        if (m_valid && m_ready) begin
          n_pop++;
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_underflow: got 0x%0h expected no pop at %0t", m_data, $time);
          end else begin
            check("sb_data", 32'(m_data), 32'(sb_q.pop_front()));
          end
        end
        if (s_valid && s_ready) sb_q.push_back(s_data);
      end
    end
  end

  typedef struct {
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    logic          e_sr;
    logic          e_mv;
    logic          e_renb;
    logic          e_we;
    logic [CW-1:0] e_cnt;
  } vec_t;
  vec_t tv [9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int acc, tot_push, p0;

  initial begin
    // Test 1 table: A0..A3 pushed back to back, m_ready held high.
    tv[0] = '{1'b1, 16'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0};
    tv[1] = '{1'b1, 16'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1};
    tv[2] = '{1'b1, 16'hA2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2};
    tv[3] = '{1'b1, 16'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3};
    tv[4] = '{1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4};
    tv[5] = '{1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3};
    tv[6] = '{1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2};
    tv[7] = '{1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1};
    tv[8] = '{1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};

    // Reset state
    #12;
    check("rst.s_ready", 32'(s_ready), 1);
    check("rst.m_valid", 32'(m_valid), 0);
    check("rst.count",   32'(count),   0);
    check("rst.empty",   32'(empty),   1);
    check("rst.full",    32'(full),    0);
    check("rst.renb",    32'(renb),    0);
    check("rst.wena",    32'(wena),    0);
    check("rst.m_data",  32'(m_data),  0);
    cyc();
    rst = 1'b0;

    // Test 1: ordered pops, first m_valid four cycles after first push
    for (int i = 0; i < 9; i++) begin
      s_valid = tv[i].sv; s_data = tv[i].d; m_ready = tv[i].mr; flush = 1'b0;
      @(negedge clk);
      check($sformatf("t1[%0d].s_ready", i), 32'(s_ready), 32'(tv[i].e_sr));
      check($sformatf("t1[%0d].m_valid", i), 32'(m_valid), 32'(tv[i].e_mv));
      check($sformatf("t1[%0d].renb", i),    32'(renb),    32'(tv[i].e_renb));
      check($sformatf("t1[%0d].wena", i),    32'(wena),    32'({SW{tv[i].e_we}}));
      check($sformatf("t1[%0d].count", i),   32'(count),   32'(tv[i].e_cnt));
      check($sformatf("t1[%0d].empty", i),   32'(empty),   32'(tv[i].e_cnt == 0));
      cyc();
    end
    tot_push = 4;

    // Test 2: fill to MEM_DEPTH+2 with m_ready low
    m_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < DEPTH + 12 && acc < DEPTH + 2; k++) begin
      s_valid = 1'b1; s_data = DW'(32'h100 + acc);
      @(negedge clk);
      if (s_ready) acc++;
      cyc();
    end
    check("t2.accepted", 32'(acc), 32'(DEPTH + 2));
    tot_push += acc;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 16'h1FF;
      @(negedge clk);
      check("t2.s_ready_blocked", 32'(s_ready), 0);
      check("t2.full", 32'(full), 1);
      cyc();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("t2.count", 32'(count), 32'(DEPTH + 2));
    check("t2.addra_wrap", 32'(addra), 32'(tot_push % DEPTH));
    check("t2.m_valid", 32'(m_valid), 1);
`ifdef SDPFIFO_ERR_EN
    check("t2.err_ovf", 32'(err_ovf), 1);
`endif
    cyc();

    // Test 3: stream push+pop from full for 3*MEM_DEPTH words
    m_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 12 * DEPTH && acc < 3 * DEPTH; k++) begin
      s_valid = 1'b1; s_data = DW'(32'h200 + acc);
      @(negedge clk);
      if (s_ready) acc++;
      cyc();
    end
    check("t3.accepted", 32'(acc), 32'(3 * DEPTH));
    tot_push += acc;
    s_valid = 1'b0;
    for (int k = 0; k < 40 && !(empty && sb_q.size() == 0); k++) cyc();
    @(negedge clk);
    check("t3.empty", 32'(empty), 1);
    check("t3.sb_left", 32'(sb_q.size()), 0);
    check("t3.addra", 32'(addra), 32'(tot_push % DEPTH));
    check("t3.addrb", 32'(addrb), 32'(tot_push % DEPTH));
`ifdef SDPFIFO_ERR_EN
    check("t3.err_ovf_sticky", 32'(err_ovf), 1);
    check("t3.err_dvalb_clean", 32'(err_dvalb), 0);
`endif
    cyc();

    // Test 4: flush with one read in flight and five words held
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_valid = 1'b1; s_data = DW'(32'h300 + k);
      cyc();
    end
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    @(negedge clk);
    check("t4.settled_count", 32'(count), 6);
    cyc();
    m_ready = 1'b1;                 // one pop (0x300), issues a refill read
    cyc();
    m_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("t4.pre_flush_count", 32'(count), 5);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("t4.count_cleared", 32'(count), 0);
    check("t4.s_ready_drain", 32'(s_ready), 0);
    check("t4.m_valid_drain", 32'(m_valid), 0);
    check("t4.renb_drain", 32'(renb), 0);
    cyc();
    @(negedge clk);
    check("t4.s_ready_back", 32'(s_ready), 1);
    check("t4.addra_reset", 32'(addra), 0);
    check("t4.m_valid_idle", 32'(m_valid), 0);
    cyc();
    p0 = n_pop;
    s_valid = 1'b1; s_data = 16'h0077; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    for (int k = 0; k < 20 && n_pop == p0; k++) cyc();
    cyc();
    check("t4.one_pop_after_flush", 32'(n_pop - p0), 1);
    check("t4.sb_left", 32'(sb_q.size()), 0);

    // Stray dvalb with nothing outstanding must be ignored (and flagged)
    m_ready = 1'b0;
    inj = 1'b1;
    cyc();
    inj = 1'b0;
    @(negedge clk);
    check("t6.stray_count", 32'(count), 0);
    check("t6.stray_m_valid", 32'(m_valid), 0);
`ifdef SDPFIFO_ERR_EN
    check("t6.err_dvalb", 32'(err_dvalb), 1);
`endif
    cyc();

    // Test 5: asynchronous reset mid-stream
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = DW'(32'h400 + k);
      cyc();
    end
    #2;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    sb_q.delete();
    #1;
    check("t5.s_ready", 32'(s_ready), 1);
    check("t5.m_valid", 32'(m_valid), 0);
    check("t5.m_data",  32'(m_data),  0);
    check("t5.count",   32'(count),   0);
    check("t5.full",    32'(full),    0);
    check("t5.empty",   32'(empty),   1);
    check("t5.wena",    32'(wena),    0);
    check("t5.renb",    32'(renb),    0);
`ifdef SDPFIFO_ERR_EN
    check("t5.err_ovf",   32'(err_ovf),   0);
    check("t5.err_dvalb", 32'(err_dvalb), 0);
`endif
    cyc();
    rst = 1'b0;
    p0 = n_pop;
    s_valid = 1'b1; s_data = 16'h0055; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    for (int k = 0; k < 20 && n_pop == p0; k++) cyc();
    cyc();
    check("t5.pop_0x55", 32'(n_pop - p0), 1);
    check("t5.sb_left", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
